// File: rtl/alu_op_sequencer_if.sv
// Request/response and datapath-strobe bundle for the ALU op sequencer.
// master = sequencer side, slave = requester/datapath side.
interface alu_op_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic [3:0] Datain;
   logic       ldA;
   logic       ldB;
   logic       aCmp;
   logic       aAdd;
   logic       aSub;
   logic       aDiv;
   logic       aMul;
   logic [7:0] Y;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_err;

   modport master (
      input  req_valid, req_op, req_a, req_b, Y, rsp_ready,
      output req_ready, Datain, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
             rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      output req_valid, req_op, req_a, req_b, Y, rsp_ready,
      input  req_ready, Datain, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
             rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Turns one opcode+operand request into the ALU datapath load/operate strobe
// sequence and returns the sampled Y result on a valid/ready response channel.
module alu_op_sequencer #(
   parameter int unsigned EXEC_CYCLES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_op_sequencer_if.master bus,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);
   localparam int unsigned EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam int unsigned OPS    = 5;

   typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_EXEC, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [3:0]         b_q, b_d;
   logic [EXEC_W-1:0]  cnt_q, cnt_d;
   logic [3:0]         datain_q, datain_d;
   logic               ld_a_q, ld_a_d;
   logic               ld_b_q, ld_b_d;
   logic [OPS-1:0]     strb_q, strb_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [7:0]         rsp_data_q, rsp_data_d;
   logic [1:0]         rsp_err_q, rsp_err_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   op_count_q, op_count_d;

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      datain_d    = datain_q;
      ld_a_d      = 1'b0;
      ld_b_d      = 1'b0;
      strb_d      = strb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      op_count_d  = op_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d = bus.req_op;
               b_d  = bus.req_b;
               if (bus.req_op > 3'd4) begin
                  state_d     = S_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'h00;
                  rsp_err_d   = 2'b01;
               end else if (bus.req_op == 3'd3 && bus.req_b == 4'd0) begin
                  state_d     = S_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'hFF;
                  rsp_err_d   = 2'b10;
               end else begin
                  state_d  = S_LDA;
                  datain_d = bus.req_a;
                  ld_a_d   = 1'b1;
               end
            end
         end
         S_LDA: begin
            state_d  = S_LDB;
            datain_d = b_q;
            ld_b_d   = 1'b1;
         end
         S_LDB: begin
            state_d = S_EXEC;
            cnt_d   = EXEC_W'(EXEC_CYCLES - 1);
            strb_d  = OPS'(1) << op_q;
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               state_d     = S_DONE;
               strb_d      = '0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = bus.Y;
               rsp_err_d   = 2'b00;
            end else begin
               cnt_d = cnt_q - EXEC_W'(1);
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         datain_q    <= '0;
         ld_a_q      <= 1'b0;
         ld_b_q      <= 1'b0;
         strb_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= '0;
         busy_q      <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         datain_q    <= datain_d;
         ld_a_q      <= ld_a_d;
         ld_b_q      <= ld_b_d;
         strb_q      <= strb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         op_count_q  <= op_count_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.Datain    = datain_q;
   assign bus.ldA       = ld_a_q;
   assign bus.ldB       = ld_b_q;
   assign bus.aCmp      = strb_q[0];
   assign bus.aAdd      = strb_q[1];
   assign bus.aSub      = strb_q[2];
   assign bus.aDiv      = strb_q[3];
   assign bus.aMul      = strb_q[4];
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;
   assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: clocked datapath model on the strobe
// side, opcode-level reference model for results and per-cycle strobe schedule.
module tb_alu_op_sequencer;
   localparam int unsigned EXEC_CYCLES = 2;
   localparam int unsigned CNT_W       = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             busy;
   logic [CNT_W-1:0] op_count;
   logic             mon_en = 1'b0;
   int               n_checks = 0;
   int               n_pass   = 0;
   int               n_fail   = 0;
   int               exp_count = 0;
   logic [3:0]       dp_a, dp_b;

   alu_op_sequencer_if bus ();

   alu_op_sequencer #(.EXEC_CYCLES(EXEC_CYCLES), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [4:0] strobes();
      return {bus.aMul, bus.aDiv, bus.aSub, bus.aAdd, bus.aCmp};
   endfunction

   // Datapath model: operand registers and a clocked result stage driven by the strobes.
   function automatic logic [7:0] dp_eval(input logic [4:0] s, input logic [3:0] x, input logic [3:0] y);
      if (s == 5'b00001) return 8'({x < y, x == y, x > y});
      if (s == 5'b00010) return 8'(x) + 8'(y);
      if (s == 5'b00100) return 8'(x) - 8'(y);
      if (s == 5'b01000) return (y == 4'd0) ? 8'hEE : 8'(x / y);
      if (s == 5'b10000) return 8'(x) * 8'(y);
      return 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (bus.ldA) dp_a <= bus.Datain;
      if (bus.ldB) dp_b <= bus.Datain;
      bus.Y <= dp_eval(strobes(), dp_a, dp_b);
   end

   // Reference: {rsp_err, rsp_data} for a request, straight from the opcode rules.
   function automatic logic [9:0] ref_rsp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0:    return {2'b00, 8'({a < b, a == b, a > b})};
         3'd1:    return {2'b00, 8'(a + 5'd0 + b)};
         3'd2:    return {2'b00, 8'(8'(a) - 8'(b))};
         3'd3:    return (b == 4'd0) ? {2'b10, 8'hFF} : {2'b00, 8'(a / b)};
         3'd4:    return {2'b00, 8'(8'(a) * 8'(b))};
         default: return {2'b01, 8'h00};
      endcase
   endfunction

   // Per-cycle invariants on the strobe side.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("strobe_onehot", 32'($countones(strobes()) <= 1), 1);
         chk("ld_exclusive", bus.ldA & bus.ldB, 0);
         chk("quiet_idle_done", (bus.req_ready | bus.rsp_valid) & (|{strobes(), bus.ldA, bus.ldB}), 0);
         chk("busy_vs_ready", busy, !bus.req_ready);
      end
   end

   task automatic scramble();
      bus.req_valid = 1'($urandom);
      bus.req_op    = 3'($urandom);
      bus.req_a     = 4'($urandom);
      bus.req_b     = 4'($urandom);
   endtask

   // One transaction from an IDLE negedge to the negedge after its handshake.
   task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int dly);
      logic [9:0] r;
      logic [4:0] exp_s;
      r = ref_rsp(op, a, b);
      chk("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = (dly == 0);
      if (r[9:8] == 2'b00) begin
         exp_s = 5'd1 << op;
         for (int k = 1; k <= 2 + int'(EXEC_CYCLES); k++) begin
            @(negedge clk);
            scramble();
            chk("ldA", bus.ldA, k == 1);
            chk("ldB", bus.ldB, k == 2);
            chk("datain", bus.Datain, (k == 1) ? a : b);
            chk("op_strobe", strobes(), (k >= 3) ? exp_s : 5'd0);
            chk("rsp_valid_early", bus.rsp_valid, 0);
            chk("busy_exec", busy, 1);
         end
      end
      @(negedge clk);
      scramble();
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_data", bus.rsp_data, r[7:0]);
      chk("rsp_err", bus.rsp_err, r[9:8]);
      chk("strobes_done", {strobes(), bus.ldA, bus.ldB}, 0);
      for (int d = 0; d < dly; d++) begin
         @(negedge clk);
         scramble();
         chk("rsp_hold_valid", bus.rsp_valid, 1);
         chk("rsp_hold_data", {bus.rsp_err, bus.rsp_data}, r);
         chk("req_ready_done", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("rsp_valid_drop", bus.rsp_valid, 0);
      chk("req_ready_back", bus.req_ready, 1);
      chk("op_count", op_count, exp_count);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rop;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      bus.Y = '0;
      dp_a = '0;
      dp_b = '0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_datain", bus.Datain, 0);
      chk("rst_strobes", {strobes(), bus.ldA, bus.ldB}, 0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("req_ready_after_rst", bus.req_ready, 1);

      run_op(3'd1, 4'd3, 4'd5, 0);
      run_op(3'd4, 4'd15, 4'd15, 5);
      run_op(3'd3, 4'd9, 4'd0, 1);
      run_op(3'd3, 4'd9, 4'd2, 0);
      run_op(3'd6, 4'd1, 4'd1, 2);
      run_op(3'd2, 4'd7, 4'd2, 0);
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(7));
         run_op(rop, 4'($urandom), ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom), $urandom_range(3));
      end

      // Reset while a CMP is executing.
      bus.req_valid = 1'b1;
      bus.req_op = 3'd0;
      bus.req_a = 4'd4;
      bus.req_b = 4'd9;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cmp_in_exec", strobes(), 5'b00001);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes", {strobes(), bus.ldA, bus.ldB}, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_op_count", op_count, 0);
      rst_n = 1'b1;
      exp_count = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", bus.rsp_valid, 0);
      end
      chk("rst_mid_count_hold", op_count, 0);

      for (int i = 0; i < 256; i++) run_op(3'd1, 4'($urandom), 4'($urandom), 0);
      chk("op_count_wrap", op_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
